// File: rtl/tcm_boot_loader.sv
// tcm_boot_loader: boot-time TCM filler. Packs a byte stream into little-endian
// 32-bit words, writes them through a request/grant port and holds the core in
// reset until the requested number of words has been stored.
// Optional checksum trailer: define TCM_BOOT_LOADER_CHECKSUM_EN.
module tcm_boot_loader #(
    parameter int AW      = 14,
    parameter int TIMEOUT = 1000000,
    parameter int TW      = 24
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    input  logic          byte_vld_i,
    input  logic [7:0]    byte_i,
    output logic          byte_rdy_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_gnt_i,
    output logic          core_rst_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW:0]   words_o
);

    localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   ONE_W   = 1;
    localparam logic [AW-1:0] ONE_A   = 1;
    localparam logic [TW-1:0] ONE_T   = 1;
    // Counter value seen on the last idle cycle before the timeout fires.
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE, ERR} state_t;
    localparam state_t FINISH = CHECK;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;
    localparam state_t FINISH = DONE;
`endif

    state_t        state;
    state_t        next_state;
    logic [AW:0]   len_q;
    logic [1:0]    byte_cnt;
    logic [TW-1:0] to_cnt;
    logic          accept;
    logic          start_ok;
    logic          to_fire;
    logic          word_last;
    logic          rx_state;
    logic          rx_next;

    assign accept    = byte_vld_i && byte_rdy_o;
    assign start_ok  = start_i && (state == IDLE || state == DONE || state == ERR);
    assign to_fire   = (TIMEOUT != 0) && !accept && (to_cnt == TO_LAST);
    assign word_last = (words_o + ONE_W) == len_q;

`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_total;
    assign sum_total = sum + byte_i;
    assign rx_state  = (state == RECV) || (state == CHECK);
    assign rx_next   = (next_state == RECV) || (next_state == CHECK);
`else
    assign rx_state  = (state == RECV);
    assign rx_next   = (next_state == RECV);
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        next_state = FINISH;
                    end else if (len_i > DEPTH) begin
                        next_state = ERR;
                    end else begin
                        next_state = RECV;
                    end
                end
            end
            RECV: begin
                if (accept && byte_cnt == 2'd3) begin
                    next_state = WRITE;
                end else if (to_fire) begin
                    next_state = ERR;
                end
            end
            WRITE: begin
                if (mem_gnt_i) begin
                    next_state = word_last ? FINISH : RECV;
                end
            end
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    next_state = (sum_total == 8'd0) ? DONE : ERR;
                end else if (to_fire) begin
                    next_state = ERR;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Registered outputs derived from the next state, plus word assembly and counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            byte_rdy_o  <= 1'b0;
            mem_we_o    <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            core_rst_o  <= 1'b1;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            words_o     <= '0;
            len_q       <= '0;
            byte_cnt    <= '0;
            to_cnt      <= '0;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            byte_rdy_o <= rx_next;
            mem_we_o   <= (next_state == WRITE);
            busy_o     <= rx_next || (next_state == WRITE);
            done_o     <= (next_state == DONE);
            err_o      <= (next_state == ERR);
            core_rst_o <= (next_state != DONE);
            if (start_ok) begin
                len_q      <= len_i;
                words_o    <= '0;
                mem_addr_o <= '0;
                byte_cnt   <= '0;
                to_cnt     <= '0;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
                sum        <= '0;
`endif
            end else if (state == WRITE) begin
                if (mem_gnt_i) begin
                    words_o    <= words_o + ONE_W;
                    mem_addr_o <= mem_addr_o + ONE_A;
                end
            end else if (rx_state) begin
                // Idle cycles are counted only while waiting for a byte.
                to_cnt <= accept ? '0 : to_cnt + ONE_T;
                if (state == RECV && accept) begin
                    mem_wdata_o[{byte_cnt, 3'b000} +: 8] <= byte_i;
                    byte_cnt <= byte_cnt + 2'd1;
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
                    sum      <= sum + byte_i;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Self-checking bench for tcm_boot_loader: directed cases plus randomized loads
// compared against a word-list model built from the byte stream.
`timescale 1ns/1ps
module tb_tcm_boot_loader;

    localparam int AW      = 4;
    localparam int DEPTH   = 1 << AW;
    localparam int TIMEOUT = 20;
    localparam int TW      = 8;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic          byte_vld_i = 1'b0;
    logic [7:0]    byte_i = '0;
    logic          byte_rdy_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic          core_rst_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   words_o;

    always #5 clk = ~clk;

    tcm_boot_loader #(.AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .len_i      (len_i),
        .byte_vld_i (byte_vld_i),
        .byte_i     (byte_i),
        .byte_rdy_o (byte_rdy_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i  (mem_gnt_i),
        .core_rst_o (core_rst_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .words_o    (words_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Grant responder: tied high, fixed delay, or random delay per write.
    int gnt_delay = 0;
    bit gnt_rand  = 1'b0;
    bit gnt_tie   = 1'b0;
    int wait_cnt  = 0;
    always begin
        @(posedge clk);
        #2;
        if (gnt_tie) begin
            mem_gnt_i = 1'b1;
        end else if (mem_we_o) begin
            if (wait_cnt == 0 && gnt_rand) gnt_delay = $urandom_range(0, 3);
            mem_gnt_i = (wait_cnt >= gnt_delay);
            wait_cnt++;
        end else begin
            mem_gnt_i = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Write monitor: collects granted writes and checks the request is held stable.
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            we_len[$];
    int            we_run = 0;
    logic          prev_pend = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [31:0]   prev_data = '0;
    always @(negedge clk) begin
        if (rst_i) begin
            we_run    = 0;
            prev_pend = 1'b0;
        end else begin
            if (mem_we_o) begin
                check_val("rdy_low_in_write", 32'(byte_rdy_o), 32'd0);
                if (prev_pend) begin
                    check_val("addr_stable", 32'(mem_addr_o), 32'(prev_addr));
                    check_val("data_stable", mem_wdata_o, prev_data);
                end
                we_run++;
                if (mem_gnt_i) begin
                    got_addr.push_back(mem_addr_o);
                    got_data.push_back(mem_wdata_o);
                    we_len.push_back(we_run);
                    we_run = 0;
                end
            end
            prev_pend = mem_we_o && !mem_gnt_i;
            prev_addr = mem_addr_o;
            prev_data = mem_wdata_o;
        end
    end

    logic [7:0] stim[$];

    task automatic fill_random(input int n);
        stim.delete();
        repeat (n) stim.push_back(8'($urandom));
    endtask

    task automatic check_reset_state();
        check_val("rst_byte_rdy", 32'(byte_rdy_o), 32'd0);
        check_val("rst_mem_we", 32'(mem_we_o), 32'd0);
        check_val("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        check_val("rst_mem_wdata", mem_wdata_o, 32'd0);
        check_val("rst_core_rst", 32'(core_rst_o), 32'd1);
        check_val("rst_busy", 32'(busy_o), 32'd0);
        check_val("rst_done", 32'(done_o), 32'd0);
        check_val("rst_err", 32'(err_o), 32'd0);
        check_val("rst_words", 32'(words_o), 32'd0);
    endtask

    task automatic do_start(input int len);
        start_i = 1'b1;
        len_i   = (AW + 1)'(len);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_vld_i = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_vld_i = 1'b1;
        byte_i     = b;
        n = 0;
        while (!byte_rdy_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check_val("rdy_wait_expired", 32'(byte_rdy_o), 32'd1);
        @(posedge clk);
        #1;
        byte_vld_i = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!done_o && !err_o && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) check_val("end_wait_expired", 32'(done_o | err_o), 32'd1);
    endtask

    // Full load of len words from stim[]; the expected writes are word i at
    // address i, assembled LSB-first from stim[4i..4i+3].
    task automatic run_load(input int len, input int gdelay, input bit grand,
                            input bit gaps, input bit bad_trl, input bit poke);
        logic [7:0]  sum;
        logic [7:0]  trl;
        logic [31:0] exp_word;
        bit          exp_ok;
        sum = 8'd0;
        got_addr.delete();
        got_data.delete();
        we_len.delete();
        gnt_delay = gdelay;
        gnt_rand  = grand;
        do_start(len);
        check_val("busy_after_start", 32'(busy_o), 32'd1);
        check_val("core_rst_loading", 32'(core_rst_o), 32'd1);
        check_val("words_cleared", 32'(words_o), 32'd0);
        for (int i = 0; i < 4 * len; i++) begin
            send_byte(stim[i], gaps ? int'($urandom_range(0, 3)) : 0);
            sum = sum + stim[i];
            if (poke && i == 3 && len >= 2) begin
                start_i = 1'b1;
                len_i   = '0;
                @(posedge clk);
                #1;
                start_i = 1'b0;
            end
        end
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
        trl = 8'd0 - sum;
        if (bad_trl) trl = trl - 8'd1;
        send_byte(trl, 0);
        exp_ok = !bad_trl;
`else
        trl    = 8'd0;
        exp_ok = 1'b1;
`endif
        wait_end();
        check_val("load_done", 32'(done_o), 32'(exp_ok));
        check_val("load_err", 32'(err_o), 32'(!exp_ok));
        check_val("load_core_rst", 32'(core_rst_o), 32'(!exp_ok));
        check_val("load_busy", 32'(busy_o), 32'd0);
        check_val("load_words", 32'(words_o), 32'(len));
        check_val("n_writes", 32'(got_addr.size()), 32'(len));
        for (int i = 0; i < len && i < got_addr.size(); i++) begin
            exp_word = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            check_val("write_addr", 32'(got_addr[i]), 32'(i % DEPTH));
            check_val("write_data", got_data[i], exp_word);
        end
        if (!grand) begin
            foreach (we_len[i]) check_val("we_cycles", 32'(we_len[i]), 32'(gdelay + 1));
        end
`ifndef TCM_BOOT_LOADER_CHECKSUM_EN
        byte_vld_i = 1'b1;
        byte_i     = 8'hA5;
        @(posedge clk);
        #1;
        check_val("no_byte_after_done", 32'(byte_rdy_o), 32'd0);
        check_val("words_hold", 32'(words_o), 32'(len));
        byte_vld_i = 1'b0;
`endif
        if (trl == 8'hFF) check_val("trailer_marker", 32'(trl), 32'h000000FF);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst_i = 1'b0;

        // Two fixed words, grant tied high.
        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        gnt_tie = 1'b1;
        run_load(2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        gnt_tie = 1'b0;
        if (got_data.size() == 2) begin
            check_val("t1_word0", got_data[0], 32'h12345678);
            check_val("t1_word1", got_data[1], 32'hDEADBEEF);
        end

        // One word, grant delayed 5 cycles.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        if (got_data.size() == 1) check_val("t2_word0", got_data[0], 32'h04030201);

        // Stream stalls after 6 bytes of a 4-word load.
        fill_random(6);
        gnt_delay = 0;
        gnt_rand  = 1'b0;
        do_start(4);
        for (int i = 0; i < 6; i++) send_byte(stim[i], 0);
        n = 0;
        while (!err_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("timeout_cycles", 32'(n), 32'(TIMEOUT));
        check_val("timeout_core_rst", 32'(core_rst_o), 32'd1);
        check_val("timeout_words", 32'(words_o), 32'd1);
        check_val("timeout_busy", 32'(busy_o), 32'd0);
        check_val("timeout_done", 32'(done_o), 32'd0);

        // Zero-length load.
        do_start(0);
`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
        check_val("len0_busy", 32'(busy_o), 32'd1);
        check_val("len0_trailer_rdy", 32'(byte_rdy_o), 32'd1);
        send_byte(8'h00, 0);
        wait_end();
`endif
        check_val("len0_done", 32'(done_o), 32'd1);
        check_val("len0_err", 32'(err_o), 32'd0);
        check_val("len0_core_rst", 32'(core_rst_o), 32'd0);
        check_val("len0_words", 32'(words_o), 32'd0);

        // Oversized load.
        do_start(DEPTH + 1);
        check_val("oversize_err", 32'(err_o), 32'd1);
        check_val("oversize_done", 32'(done_o), 32'd0);
        check_val("oversize_core_rst", 32'(core_rst_o), 32'd1);
        check_val("oversize_busy", 32'(busy_o), 32'd0);

        // Reset in the middle of word 3, then a fresh load.
        fill_random(16);
        do_start(4);
        for (int i = 0; i < 10; i++) send_byte(stim[i], 0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        rst_i = 1'b0;
        fill_random(4);
        run_load(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full-depth load with random grant latency; address wraps afterwards.
        fill_random(4 * DEPTH);
        run_load(DEPTH, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("addr_wrap", 32'(mem_addr_o), 32'd0);

        // Randomized loads with gaps, random grants and an ignored mid-load start.
        for (int t = 0; t < 6; t++) begin
            int len;
            len = $urandom_range(1, 5);
            fill_random(4 * len);
            run_load(len, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
        end

`ifdef TCM_BOOT_LOADER_CHECKSUM_EN
        // Checksum trailer good, then bad.
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_load(1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
